// File: rtl/feature_mac.sv
// Streaming multiply-accumulate for Haar features: truncating product, per-feature
// accumulation, threshold compare. Define FEATURE_MAC_SAT_EN for a saturating accumulator.
module feature_mac #(
   parameter int unsigned MAX_TERMS = 3,
   parameter int unsigned ACC_W     = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ACC_W-1:0] rect_sum,
   input  logic [ACC_W-1:0] weight,
   input  logic             in_last,
   input  logic [ACC_W-1:0] threshold,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] feature_sum,
   output logic             above_thr,
   output logic             term_err
);

   localparam int unsigned CNT_W = $clog2(MAX_TERMS + 1);

   typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

   state_t             state_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [ACC_W-1:0]   feature_sum_q;
   logic               above_thr_q;
   logic               term_err_q;

   logic [CNT_W-1:0]   cnt_q;
   logic               s1_valid_q;
   logic [ACC_W-1:0]   s1_prod_q;
   logic               s1_last_q;
   logic [ACC_W-1:0]   s1_thr_q;
   logic               s1_err_q;
   logic               s1_first_q;
   logic [ACC_W-1:0]   acc_q;

   logic               accept;
   logic               at_max;
   logic               last_d;
   logic               err_d;
   logic [ACC_W-1:0]   prod_d;
   logic [ACC_W-1:0]   add_d;
   logic [ACC_W-1:0]   sum_d;
`ifdef FEATURE_MAC_SAT_EN
   logic               ovf_d;
`endif

   always_comb begin
      accept = in_valid && in_ready_q;
      at_max = (cnt_q == CNT_W'(MAX_TERMS - 1));
      last_d = in_last || at_max;
      err_d  = at_max && !in_last;
      // Low ACC_W bits of the product are identical for signed and unsigned operands.
      prod_d = rect_sum * weight;
      add_d  = acc_q + s1_prod_q;
`ifdef FEATURE_MAC_SAT_EN
      ovf_d  = (acc_q[ACC_W-1] == s1_prod_q[ACC_W-1]) && (add_d[ACC_W-1] != acc_q[ACC_W-1]);
      if (ovf_d) begin
         add_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`endif
      sum_d  = s1_first_q ? s1_prod_q : add_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_last_q  <= 1'b0;
         s1_thr_q   <= '0;
         s1_err_q   <= 1'b0;
         s1_first_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_prod_q  <= prod_d;
            s1_last_q  <= last_d;
            s1_thr_q   <= threshold;
            s1_err_q   <= err_d;
            s1_first_q <= (cnt_q == '0);
            cnt_q      <= last_d ? '0 : cnt_q + CNT_W'(1);
         end
         if (s1_valid_q) begin
            acc_q <= sum_d;
         end
      end
   end

   // Result registers load on the cycle stage 2 retires the final term (the FLUSH cycle).
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ACCUM;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         feature_sum_q <= '0;
         above_thr_q   <= 1'b0;
         term_err_q    <= 1'b0;
      end else begin
         if (s1_valid_q && s1_last_q) begin
            feature_sum_q <= sum_d;
            above_thr_q   <= ($signed(sum_d) >= $signed(s1_thr_q));
            term_err_q    <= s1_err_q;
         end
         case (state_q)
            ACCUM: begin
               if (accept && last_d) begin
                  state_q    <= FLUSH;
                  in_ready_q <= 1'b0;
               end
            end
            FLUSH: begin
               state_q     <= DONE;
               out_valid_q <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= ACCUM;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ACCUM;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign feature_sum = feature_sum_q;
   assign above_thr   = above_thr_q;
   assign term_err    = term_err_q;

endmodule
